// File: rtl/fb_scanout_pkg.sv
// Shared 640x480@60 timing constants, frame buffer geometry and swap FSM state type.
package fb_scanout_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int FB_SIZE_D  = 307200;

  localparam int H_TOTAL  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
  localparam int HS_START = H_ACTIVE_D + H_FP_D;
  localparam int HS_END   = HS_START + H_SYNC_D - 1;
  localparam int VS_START = V_ACTIVE_D + V_FP_D;
  localparam int VS_END   = VS_START + V_SYNC_D - 1;

  typedef enum logic {
    SW_IDLE = 1'b0,
    SW_ACK  = 1'b1
  } swap_state_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v counters with active flag, raw active-low syncs and line/frame wrap strobes.
module vga_timing_gen import fb_scanout_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       active,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       line_end,
  output logic       wrap
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_S   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_E   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_S   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_E   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  assign line_end  = (h_cnt == H_LAST);
  assign wrap      = line_end && (v_cnt == V_LAST);
  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync_raw = !((h_cnt >= HS_S) && (h_cnt <= HS_E));
  assign vsync_raw = !((v_cnt >= VS_S) && (v_cnt <= VS_E));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// Front-buffer scanout: address generation, frame-boundary swap handshake, and
// sync/de delay matched to the frame buffer read latency ahead of the output register.
module fb_scanout import fb_scanout_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int FB_SIZE  = FB_SIZE_D,
  parameter int MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [19:0] read_addr,
  input  logic [1:0]  pix_r,
  input  logic [1:0]  pix_g,
  input  logic [1:0]  pix_b,
  output logic [1:0]  vga_r,
  output logic [1:0]  vga_g,
  output logic [1:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        front_sel
);

  logic [9:0]  h_cnt, v_cnt;
  logic        active, hs_raw, vs_raw, line_end, wrap;
  logic [18:0] pix_idx;
  logic        idx_inc;
  swap_state_t sw_state;

  logic [MEM_LAT-1:0] dl_hs, dl_vs, dl_de;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (active),
    .hsync_raw (hs_raw),
    .vsync_raw (vs_raw),
    .line_end  (line_end),
    .wrap      (wrap)
  );

  // The index stops on the last pixel of each line so the address holds the last
  // fetched word through blanking, then steps to the next line's first pixel.
  assign idx_inc = (active && (h_cnt != 10'(H_ACTIVE - 1)))
                 || (line_end && (v_cnt < 10'(V_ACTIVE - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pix_idx <= '0;
    else if (wrap)    pix_idx <= '0;
    else if (idx_inc) pix_idx <= pix_idx + 19'd1;
  end

  assign read_addr = (front_sel ? 20'(FB_SIZE) : 20'd0) + {1'b0, pix_idx};

  // Swap decision is taken only on the wrap cycle, so front_sel cannot move mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_state  <= SW_IDLE;
      front_sel <= 1'b0;
      swap_ack  <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (sw_state)
        SW_IDLE: if (wrap && swap_req) begin
          sw_state  <= SW_ACK;
          front_sel <= !front_sel;
          swap_ack  <= 1'b1;
        end
        SW_ACK:  sw_state <= SW_IDLE;
        default: sw_state <= SW_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_start <= 1'b0;
    else        frame_start <= wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_hs <= '1;
      dl_vs <= '1;
      dl_de <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
      vga_r <= 2'b00;
      vga_g <= 2'b00;
      vga_b <= 2'b00;
    end else begin
      dl_hs[0] <= hs_raw;
      dl_vs[0] <= vs_raw;
      dl_de[0] <= active;
      for (int i = 1; i < MEM_LAT; i++) begin
        dl_hs[i] <= dl_hs[i-1];
        dl_vs[i] <= dl_vs[i-1];
        dl_de[i] <= dl_de[i-1];
      end
      hsync <= dl_hs[MEM_LAT-1];
      vsync <= dl_vs[MEM_LAT-1];
      de    <= dl_de[MEM_LAT-1];
      vga_r <= dl_de[MEM_LAT-1] ? pix_r : 2'b00;
      vga_g <= dl_de[MEM_LAT-1] ? pix_g : 2'b00;
      vga_b <= dl_de[MEM_LAT-1] ? pix_b : 2'b00;
    end
  end

endmodule
